// File: rtl/uart_rx_checker.sv
// uart_rx_checker
//   Receive end of the 8N1 "Hello World!\n" beacon. Deserialises LSB-first
//   8N1 frames into bytes, presents them on a valid/ready interface, flags
//   framing and overrun errors and, optionally, checks the byte stream
//   against the beacon message.
//
// Build option:
//   UART_RX_MSG_CHECK_EN  defined   -> message checker drives msg_ok/msg_err
//                         undefined -> msg_ok/msg_err tied low
//
// Parameters:
//   CLKS_PER_BIT  clocks per UART bit (4..256)
//   MSG_LEN       expected message length (checker only)
//
// Ports:
//   clk            clock
//   reset          synchronous, active-high reset
//   rx             asynchronous serial line, idle high
//   rx_ready       consumer accepts rx_data when high with rx_valid
//   rx_data        last received byte
//   rx_valid       rx_data holds an unconsumed byte
//   framing_error  1-cycle pulse: stop bit sampled low
//   overrun        1-cycle pulse: previous byte lost (not consumed)
//   msg_ok         1-cycle pulse: full expected message received
//   msg_err        1-cycle pulse: received byte differs from expected byte
module uart_rx_checker #(
    parameter int CLKS_PER_BIT = 4,
    parameter int MSG_LEN      = 13
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       framing_error,
    output logic       overrun,
    output logic       msg_ok,
    output logic       msg_err
);

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 256 || MSG_LEN < 2) begin : g_bad_param
        $error("uart_rx_checker: CLKS_PER_BIT must be 4..256 and MSG_LEN >= 2");
    end

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_sync1, r_sync2;
    logic          w_rx_s;
    logic          w_byte_done;
    logic          w_frame_err;

    assign w_rx_s = r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1       <= 1'b1;
            r_sync2       <= 1'b1;
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_bit         <= '0;
            r_shift       <= '0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            r_sync1       <= rx;
            r_sync2       <= r_sync1;
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_bit         <= w_bit_nxt;
            r_shift       <= w_shift_nxt;
            framing_error <= w_frame_err;
            // A completing byte overwrites an unconsumed one unless it is
            // being consumed in this very cycle.
            overrun       <= w_byte_done & rx_valid & ~rx_ready;
            if (w_byte_done) begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // The counter is cleared on entry to START, so the start-bit check lands
    // H cycles after the first low sample and each following sample lands a
    // full bit period later, i.e. mid-bit.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_byte_done = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rx_s) w_state_nxt = S_START;
            end
            S_START: begin
                if (r_cnt == H_LAST) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rx_s, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 1'b1;
                    if (r_bit == 3'd7) w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_rx_s) begin
                        w_byte_done = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state_nxt = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                w_cnt_nxt = '0;
                if (w_rx_s) w_state_nxt = S_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef UART_RX_MSG_CHECK_EN
    localparam int IW = $clog2(MSG_LEN);
    localparam logic [IW-1:0] IDX_LAST = IW'(MSG_LEN - 1);

    logic [IW-1:0] r_idx;
    logic [7:0]    w_expected;

    function automatic logic [7:0] f_expected(input logic [IW-1:0] idx);
        case (int'(idx))
            0:       f_expected = 8'h48; // H
            1:       f_expected = 8'h65; // e
            2:       f_expected = 8'h6C; // l
            3:       f_expected = 8'h6C; // l
            4:       f_expected = 8'h6F; // o
            5:       f_expected = 8'h20; // space
            6:       f_expected = 8'h57; // W
            7:       f_expected = 8'h6F; // o
            8:       f_expected = 8'h72; // r
            9:       f_expected = 8'h6C; // l
            10:      f_expected = 8'h64; // d
            11:      f_expected = 8'h21; // !
            12:      f_expected = 8'h0A; // \n
            default: f_expected = 8'h00;
        endcase
    endfunction

    assign w_expected = f_expected(r_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx   <= '0;
            msg_ok  <= 1'b0;
            msg_err <= 1'b0;
        end else begin
            msg_ok  <= 1'b0;
            msg_err <= 1'b0;
            if (w_frame_err) begin
                r_idx <= '0;
            end else if (w_byte_done) begin
                if (r_shift == w_expected) begin
                    if (r_idx == IDX_LAST) begin
                        msg_ok <= 1'b1;
                        r_idx  <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end else begin
                    // A stray 'H' is itself a valid message start.
                    msg_err <= 1'b1;
                    r_idx   <= (r_shift == 8'h48) ? IW'(1) : '0;
                end
            end
        end
    end
`else
    assign msg_ok  = 1'b0;
    assign msg_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_checker.sv
module tb_uart_rx_checker;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_error;
    logic       overrun;
    logic       msg_ok;
    logic       msg_err;

    uart_rx_checker #(.CLKS_PER_BIT(CPB), .MSG_LEN(13)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .framing_error (framing_error),
        .overrun       (overrun),
        .msg_ok        (msg_ok),
        .msg_err       (msg_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_loads  = 0;
    int n_fe     = 0;
    int n_ov     = 0;
    int n_ok     = 0;
    int n_err    = 0;
    logic prev_valid = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame starting at the current cycle; a good frame's byte
    // is queued as the expected next load.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        rx = stop;
        if (stop) exp_q.push_back(b);
        repeat (CPB) tick();
        rx = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    // Load monitor: a load is a rising rx_valid or an overrun (overwrite).
    always @(negedge clk) begin
        logic is_load;
        is_load = 1'b0;
        if (!reset) begin
            is_load = (rx_valid && !prev_valid) || overrun;
            if (is_load) begin
                n_loads++;
                if (exp_q.size() == 0)
                    check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
                else
                    check("sb_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
            if (msg_ok || msg_err) check("msg_at_load", 32'(is_load), 32'd1);
            if (framing_error) n_fe++;
            if (overrun)       n_ov++;
            if (msg_ok)        n_ok++;
            if (msg_err)       n_err++;
        end
        prev_valid = rx_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int loads0, fe0, ov0, ok0, err0;

        reset = 1'b1; rx = 1'b1; rx_ready = 1'b1;
        repeat (5) tick();
        reset = 1'b0;
        repeat (50) tick();
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data",  32'(rx_data), 32'h00);
        check("rst_fe",    32'(framing_error), 32'd0);
        check("rst_ov",    32'(overrun), 32'd0);
        check("rst_ok",    32'(msg_ok), 32'd0);
        check("rst_err",   32'(msg_err), 32'd0);
        check("rst_loads", 32'(n_loads), 32'd0);

        // 0x48: stop sample at P+40, rx_valid high only at P+41
        send_byte(8'h48, 1'b1);
        check("t48_valid_p40", 32'(rx_valid), 32'd0);
        tick();
        check("t48_valid_p41", 32'(rx_valid), 32'd1);
        check("t48_data_p41",  32'(rx_data), 32'h48);
        tick();
        check("t48_valid_p42", 32'(rx_valid), 32'd0);
        check("t48_loads",     32'(n_loads), 32'd1);

        // one-cycle glitch, then a real frame
        loads0 = n_loads; fe0 = n_fe;
        rx = 1'b0; tick(); rx = 1'b1;
        repeat (60) tick();
        check("glitch_loads", 32'(n_loads), 32'(loads0));
        check("glitch_fe",    32'(n_fe), 32'(fe0));
        send_byte(8'h65, 1'b1);
        repeat (5) tick();
        check("t65_loads", 32'(n_loads), 32'(loads0 + 1));

        // bad stop bit, line low 20 cycles, then recovery
        loads0 = n_loads; fe0 = n_fe;
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = ((8'h6C >> i) & 8'h01) != 0;
            repeat (CPB) tick();
        end
        rx = 1'b0;
        repeat (20) tick();
        rx = 1'b1;
        repeat (10) tick();
        check("fe_count", 32'(n_fe), 32'(fe0 + 1));
        check("fe_loads", 32'(n_loads), 32'(loads0));
        send_byte(8'h21, 1'b1);
        repeat (5) tick();
        check("t21_loads", 32'(n_loads), 32'(loads0 + 1));
        check("t21_data",  32'(rx_data), 32'h21);

        // overrun: two back-to-back frames with nobody consuming
        ov0 = n_ov;
        rx_ready = 1'b0;
        send_byte(8'h6F, 1'b1);
        send_byte(8'h20, 1'b1);
        repeat (3) tick();
        check("ov_count", 32'(n_ov), 32'(ov0 + 1));
        check("ov_valid", 32'(rx_valid), 32'd1);
        check("ov_data",  32'(rx_data), 32'h20);
        rx_ready = 1'b1;
        tick();
        check("ov_valid_cleared", 32'(rx_valid), 32'd0);

`ifdef UART_RX_MSG_CHECK_EN
        // H, e matched; framing reset; 0x21, 0x6F, 0x20 each mismatched
        check("chk_err_prior", 32'(n_err), 32'd3);
        check("chk_ok_prior",  32'(n_ok), 32'd0);
        ok0 = n_ok; err0 = n_err;
        send_str("Hello World!");
        send_byte(8'h0A, 1'b1);
        check("hello_ok_before_last", 32'(n_ok), 32'(ok0));
        repeat (3) tick();
        check("hello_ok",  32'(n_ok), 32'(ok0 + 1));
        check("hello_err", 32'(n_err), 32'(err0));

        ok0 = n_ok; err0 = n_err;
        send_str("HelXlo World!\n");
        repeat (3) tick();
        check("bad_ok",  32'(n_ok), 32'(ok0));
        check("bad_err", 32'(n_err), 32'(err0 + 11));

        ok0 = n_ok; err0 = n_err;
        send_str("Hello World!\n");
        repeat (3) tick();
        check("clean_ok",  32'(n_ok), 32'(ok0 + 1));
        check("clean_err", 32'(n_err), 32'(err0));
`else
        send_str("Hello World!\n");
        repeat (3) tick();
        check("nochk_ok",  32'(n_ok), 32'd0);
        check("nochk_err", 32'(n_err), 32'd0);
`endif

        // mid-frame reset returns everything to idle
        rx = 1'b0;
        repeat (15) tick();
        reset = 1'b1;
        tick();
        rx = 1'b1;
        tick();
        check("midrst_data",  32'(rx_data), 32'h00);
        check("midrst_valid", 32'(rx_valid), 32'd0);
        reset = 1'b0;
        repeat (60) tick();
        check("midrst_idle_valid", 32'(rx_valid), 32'd0);

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_checker.md
# uart_rx_checker

Serial UART receiver: the receive end of the team's 8N1 "Hello World!\n" beacon transmitter. It deserialises LSB-first 8N1 frames into bytes and presents them on a valid/ready interface. It flags framing and overrun errors and, optionally, checks the byte stream against the beacon message. It sits behind an `io_in` pin in a TinyTapeout user module, clocked from `io_in[0]`.

## Interface
- `CLKS_PER_BIT`, default 4: clocks per UART bit; legal range 4..256.
- `MSG_LEN`, default 13: length of the expected message (checker only).
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `rx`  in  1  asynchronous serial line, idle high.
- `rx_ready`  in  1  consumer accepts `rx_data` when high with `rx_valid`.
- `rx_data`  out  8  last received byte.
- `rx_valid`  out  1  `rx_data` holds an unconsumed byte.
- `framing_error`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: byte lost because the previous byte was not consumed.
- `msg_ok`  out  1  one-cycle pulse: full expected message received.
- `msg_err`  out  1  one-cycle pulse: received byte differs from the expected byte.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1) to give `rx_s`. All sampling uses `rx_s`.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- Let H = CLKS_PER_BIT/2 (integer division). T0 is the first cycle, in IDLE, in which `rx_s` = 0.
- Start verify at T0+H:
  - `rx_s` = 1 → glitch, return to IDLE; no output activity.
  - `rx_s` = 0 → DATA.
- DATA: bit i (i = 0..7, LSB first) is sampled at T0+H+(i+1)·CLKS_PER_BIT into a shift register.
- STOP: stop bit sampled at Ts = T0+H+9·CLKS_PER_BIT.
  - `rx_s` = 1 → byte complete; next state IDLE, so a new start edge is detectable from Ts+1.
  - `rx_s` = 0 → `framing_error` pulses at Ts+1, byte discarded, state WAIT_HIGH. WAIT_HIGH returns to IDLE on the first cycle with `rx_s` = 1.
- Byte complete at Ts: at Ts+1, `rx_data` = byte and `rx_valid` = 1.
- Handshake:
  - `rx_valid` holds until a cycle with `rx_valid` & `rx_ready`; it clears the next cycle.
  - `rx_data` is stable while `rx_valid` = 1, except on overrun.
  - Byte completes in the same cycle as a handshake → new byte loads, `rx_valid` stays 1, no overrun.
  - Byte completes while `rx_valid` = 1 and `rx_ready` = 0 → `rx_data` is overwritten, `rx_valid` stays 1, `overrun` pulses at Ts+1.
- Reset, at any time including mid-frame: state IDLE, `rx_data` = 0, `rx_valid` = 0, all pulse outputs 0, synchronizer = 1, checker index = 0.

## Timing
- `rx` pin falling edge at cycle P gives T0 = P+2 (synchronizer latency).
- Default CLKS_PER_BIT = 4: stop sample at P+40, `rx_valid` rises at P+41.
- Minimum frame spacing: 10·CLKS_PER_BIT cycles; back-to-back frames are received without loss.
- All outputs are registered. The pulse outputs are high for exactly one cycle.
- `msg_ok` and `msg_err` coincide with the `rx_data` load cycle (Ts+1).

## Configuration
- Macro: `UART_RX_MSG_CHECK_EN`.
- Defined:
  - Checker holds expected string "Hello World!\n" (MSG_LEN bytes) and index `idx`, 0..MSG_LEN-1.
  - Each completed byte (overrun bytes included) is compared with expected[idx].
  - Match with idx < MSG_LEN-1 → idx+1.
  - Match with idx = MSG_LEN-1 → `msg_ok` pulse, idx = 0.
  - Mismatch → `msg_err` pulse; idx = 1 if the byte is "H" (0x48), else idx = 0.
  - `framing_error` → idx = 0, no `msg_err`.
- Undefined: no checker logic; `msg_ok` and `msg_err` tied 0.

## Test plan
- Reset with `rx` = 1, then 50 idle cycles → `rx_valid`, `framing_error`, `overrun`, `msg_ok`, `msg_err` all 0; `rx_data` = 0x00.
- Frame 0x48 with `rx` falling at P, `rx_ready` = 1 → `rx_valid` high only at P+41, `rx_data` = 0x48.
- `rx` low for 1 cycle, then high → no `rx_valid`, no `framing_error`; a following 0x65 frame is received correctly.
- Frame 0x6C with stop bit 0, line held low 20 cycles then high → `framing_error` pulses once, no `rx_valid`; the next frame 0x21 is received.
- Frames 0x6F then 0x20 back-to-back with `rx_ready` = 0 → `overrun` pulse at the second byte, `rx_data` = 0x20, `rx_valid` held; `rx_ready` = 1 for one cycle → `rx_valid` clears.
- With `UART_RX_MSG_CHECK_EN` defined:
  - "Hello World!\n" back-to-back → exactly one `msg_ok`, on byte 13.
  - "HelXlo World!\n" → `msg_err` on "X", then no `msg_ok`.
  - A following clean message → `msg_ok`.
